// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - ifu fetch FSM state type, response code and default reset PC
package ifu_pkg;

    typedef enum logic [1:0] {
        LOOKUP = 2'd0,
        AR     = 2'd1,
        R      = 2'd2,
        VALID  = 2'd3
    } ifu_state_t;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h3000_0000;

endpackage

// File: rtl/ifu_perf_cnt.sv
// rtl/ifu_perf_cnt.sv - wrapping hit/miss lookup counters (used only with IFU_PERF_CNT_EN)
module ifu_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit_inc,
    input  logic        miss_inc,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    // count every lookup cycle by outcome, wrapping at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (hit_inc) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_inc) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: icache lookup, bus refill, redirect handling; IFU_PERF_CNT_EN adds perf counters
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic                  cache_req,
    input  logic [DATA_WIDTH-1:0] cache_data,
    input  logic                  cache_hit,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_err,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]           perf_hit_cnt,
    output logic [31:0]           perf_miss_cnt
`endif
);

    ifu_state_t            state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  pend_v_q;
    logic [ADDR_WIDTH-1:0] pend_pc_q;
    logic [ADDR_WIDTH-1:0] redirect_target;

    // redirect targets are forced word-aligned
    assign redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    assign cache_addr = pc_q;
    assign araddr     = pc_q;
    assign cache_req  = (state_q == LOOKUP);
    assign mem_data   = rdata;
    // only OKAY responses refill the cache, including fetches discarded by a redirect
    assign mem_valid  = (state_q == R) & rvalid & rready & (rresp == RESP_OKAY);

    // fetch FSM with registered bus/IDU handshakes and a pending-redirect slot for in-flight fetches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOOKUP;
            pc_q      <= RESET_PC;
            pend_v_q  <= 1'b0;
            pend_pc_q <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            out_valid <= 1'b0;
            inst      <= '0;
            inst_pc   <= '0;
            inst_err  <= 1'b0;
        end else begin
            case (state_q)
                LOOKUP: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_target;
                    end else if (cache_hit) begin
                        inst      <= cache_data;
                        inst_pc   <= pc_q;
                        inst_err  <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= VALID;
                    end else begin
                        arvalid <= 1'b1;
                        state_q <= AR;
                    end
                end
                AR: begin
                    if (redirect_valid) begin
                        pend_v_q  <= 1'b1;
                        pend_pc_q <= redirect_target;
                    end
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_q <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        if (redirect_valid || pend_v_q) begin
                            pc_q     <= redirect_valid ? redirect_target : pend_pc_q;
                            pend_v_q <= 1'b0;
                            state_q  <= LOOKUP;
                        end else begin
                            inst      <= rdata;
                            inst_pc   <= pc_q;
                            inst_err  <= (rresp != RESP_OKAY);
                            out_valid <= 1'b1;
                            state_q   <= VALID;
                        end
                    end else if (redirect_valid) begin
                        pend_v_q  <= 1'b1;
                        pend_pc_q <= redirect_target;
                    end
                end
                VALID: begin
                    if (redirect_valid) begin
                        pc_q      <= redirect_target;
                        out_valid <= 1'b0;
                        state_q   <= LOOKUP;
                    end else if (out_ready) begin
                        pc_q      <= pc_q + ADDR_WIDTH'(4);
                        out_valid <= 1'b0;
                        state_q   <= LOOKUP;
                    end
                end
                default: begin
                    state_q <= LOOKUP;
                end
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic lookup_hit;
    logic lookup_miss;

    assign lookup_hit  = (state_q == LOOKUP) & cache_hit;
    assign lookup_miss = (state_q == LOOKUP) & ~cache_hit;

    ifu_perf_cnt u_perf_cnt (
        .clk      (clk),
        .rst      (rst),
        .hit_inc  (lookup_hit),
        .miss_inc (lookup_miss),
        .hit_cnt  (perf_hit_cnt),
        .miss_cnt (perf_miss_cnt)
    );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] cache_addr;
    logic        cache_req;
    logic [31:0] cache_data;
    logic        cache_hit;
    logic [31:0] mem_data;
    logic        mem_valid;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        out_valid;
    logic        out_ready;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_hit_cnt;
    logic [31:0] perf_miss_cnt;
`endif

    // tiny icache model: one filled line plus one preloaded line
    logic        warm_v;
    logic [31:0] warm_addr;
    logic [31:0] warm_data;
    logic        hit_en;
    logic [31:0] hit_addr;
    logic [31:0] hit_data;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_pulses = 0;

    assign cache_hit  = cache_req && ((warm_v && cache_addr == warm_addr) || (hit_en && cache_addr == hit_addr));
    assign cache_data = (warm_v && cache_addr == warm_addr) ? warm_data : hit_data;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .cache_addr     (cache_addr),
        .cache_req      (cache_req),
        .cache_data     (cache_data),
        .cache_hit      (cache_hit),
        .mem_data       (mem_data),
        .mem_valid      (mem_valid),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_hit_cnt   (perf_hit_cnt),
        .perf_miss_cnt  (perf_miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_valid === 1'b1) mem_pulses <= mem_pulses + 1;
    end

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; arready = 1'b0;
        rdata = '0; rresp = 2'b00; rvalid = 1'b0; out_ready = 1'b0;
        warm_v = 1'b0; warm_addr = 32'h3000_0000; warm_data = 32'h0000_0413;
        hit_en = 1'b0; hit_addr = '0; hit_data = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, arvalid, rready, mem_valid, inst_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {out_valid, arvalid, rready, mem_valid, inst_err});
        end
        n_checks++;
        if ({inst, inst_pc} !== 64'h0) begin
            n_fail++; $display("FAIL reset_inst: got %h expected 0", {inst, inst_pc});
        end
        n_checks++;
        if (cache_addr !== 32'h3000_0000 || cache_req !== 1'b1) begin
            n_fail++; $display("FAIL reset_pc: got %h/%b expected 30000000/1", cache_addr, cache_req);
        end
`ifdef IFU_PERF_CNT_EN
        n_checks++;
        if ({perf_hit_cnt, perf_miss_cnt} !== 64'h0) begin
            n_fail++; $display("FAIL reset_perf: got %h expected 0", {perf_hit_cnt, perf_miss_cnt});
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        for (int i = 0; i < 20 && arvalid !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (arvalid !== 1'b1) begin
            n_fail++; $display("FAIL cold_arvalid: got %b expected 1 within 20 cycles", arvalid);
        end
        n_checks++;
        if (araddr !== 32'h3000_0000 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL cold_araddr: got %h/%b expected 30000000/0", araddr, out_valid);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        n_checks++;
        if (arvalid !== 1'b0 || rready !== 1'b1) begin
            n_fail++; $display("FAIL cold_rphase: got arvalid=%b rready=%b expected 0/1", arvalid, rready);
        end
        rvalid = 1'b1; rdata = 32'h0000_0413; rresp = 2'b00;
        #1;
        n_checks++;
        if (mem_valid !== 1'b1 || mem_data !== 32'h0000_0413 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL cold_fill: got mv=%b md=%h ov=%b expected 1/00000413/0", mem_valid, mem_data, out_valid);
        end
        @(negedge clk);
        rvalid = 1'b0;
        warm_v = 1'b1;
        n_checks++;
        if (out_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== 32'h3000_0000 || inst_err !== 1'b0) begin
            n_fail++; $display("FAIL cold_out: got %b %h %h %b expected 1 00000413 30000000 0", out_valid, inst, inst_pc, inst_err);
        end
        n_checks++;
        if (mem_pulses !== 1 || rready !== 1'b0) begin
            n_fail++; $display("FAIL cold_pulses: got %0d rready=%b expected 1/0", mem_pulses, rready);
        end
    endtask

    task automatic test_hold_then_hit();
        hit_en = 1'b1; hit_addr = 32'h3000_0004; hit_data = 32'h0010_0093;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== 32'h3000_0000) begin
                n_fail++; $display("FAIL hold_stable[%0d]: got %b %h %h expected 1 00000413 30000000", i, out_valid, inst, inst_pc);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || cache_addr !== 32'h3000_0004 || cache_req !== 1'b1) begin
            n_fail++; $display("FAIL hold_next_lookup: got %b %h %b expected 0 30000004 1", out_valid, cache_addr, cache_req);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h3000_0004 || arvalid !== 1'b0) begin
            n_fail++; $display("FAIL hit_latency: got %b %h %h ar=%b expected 1 00100093 30000004 0", out_valid, inst, inst_pc, arvalid);
        end
    endtask

    task automatic test_warm_refetch();
        hit_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h3000_0001; out_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || cache_addr !== 32'h3000_0000 || cache_req !== 1'b1) begin
            n_fail++; $display("FAIL redirect_priority: got %b %h %b expected 0 30000000 1", out_valid, cache_addr, cache_req);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== 32'h3000_0000 || arvalid !== 1'b0) begin
            n_fail++; $display("FAIL warm_hit: got %b %h %h ar=%b expected 1 00000413 30000000 0", out_valid, inst, inst_pc, arvalid);
        end
    endtask

    task automatic test_redirect_in_flight();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 20 && arvalid !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h3000_0004) begin
            n_fail++; $display("FAIL flight_ar: got %b %h expected 1 30000004", arvalid, araddr);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h7000_0000;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h3000_0004) begin
            n_fail++; $display("FAIL flight_ar_stable: got %b %h expected 1 30000004", arvalid, araddr);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++;
        if (rready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flight_r_wait: got rready=%b ov=%b expected 1/0", rready, out_valid);
        end
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        #1;
        n_checks++;
        if (mem_valid !== 1'b1 || mem_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL flight_fill: got %b %h expected 1 deadbeef", mem_valid, mem_data);
        end
        @(negedge clk);
        rvalid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || cache_addr !== 32'h8000_0000 || cache_req !== 1'b1 || rready !== 1'b0) begin
            n_fail++; $display("FAIL flight_discard: got %b %h %b %b expected 0 80000000 1 0", out_valid, cache_addr, cache_req, rready);
        end
        hit_en = 1'b1; hit_addr = 32'h8000_0000; hit_data = 32'h1111_1111;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0; hit_en = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || cache_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL redirect_over_hit: got %b %h expected 0 fffffffc", out_valid, cache_addr);
        end
    endtask

    task automatic test_error_wrap();
        for (int i = 0; i < 20 && arvalid !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL err_ar: got %b %h expected 1 fffffffc", arvalid, araddr);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_0073; rresp = 2'b10;
        #1;
        n_checks++;
        if (mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL err_no_fill: got %b expected 0", mem_valid);
        end
        @(negedge clk);
        rvalid = 1'b0; rresp = 2'b00;
        n_checks++;
        if (out_valid !== 1'b1 || inst_err !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== 32'h0000_0073) begin
            n_fail++; $display("FAIL err_out: got %b %b %h %h expected 1 1 fffffffc 00000073", out_valid, inst_err, inst_pc, inst);
        end
        n_checks++;
        if (mem_pulses !== 2) begin
            n_fail++; $display("FAIL err_pulses: got %0d expected 2", mem_pulses);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (cache_addr !== 32'h0000_0000 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL pc_wrap: got %h %b expected 00000000 0", cache_addr, out_valid);
        end
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && arvalid !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL err_refetch_miss: got %b %h expected 1 fffffffc", arvalid, araddr);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_0073; rresp = 2'b00;
        #1;
        n_checks++;
        if (mem_valid !== 1'b1) begin
            n_fail++; $display("FAIL refetch_fill: got %b expected 1", mem_valid);
        end
        @(negedge clk);
        rvalid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || inst_err !== 1'b0 || mem_pulses !== 3) begin
            n_fail++; $display("FAIL refetch_out: got %b %b %0d expected 1 0 3", out_valid, inst_err, mem_pulses);
        end
`ifdef IFU_PERF_CNT_EN
        n_checks++;
        if (perf_hit_cnt !== 32'd3 || perf_miss_cnt !== 32'd5) begin
            n_fail++; $display("FAIL perf_counts: got hit=%0d miss=%0d expected 3/5", perf_hit_cnt, perf_miss_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 20 && arvalid !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h0000_0000) begin
            n_fail++; $display("FAIL mid_ar: got %b %h expected 1 00000000", arvalid, araddr);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (arvalid !== 1'b0 || cache_addr !== 32'h3000_0000 || out_valid !== 1'b0 || {inst, inst_pc} !== 64'h0) begin
            n_fail++; $display("FAIL mid_reset: got %b %h %b %h expected 0 30000000 0 0", arvalid, cache_addr, out_valid, {inst, inst_pc});
        end
        warm_v = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20 && arvalid !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h3000_0000) begin
            n_fail++; $display("FAIL mid_restart: got %b %h expected 1 30000000", arvalid, araddr);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hold_then_hit();
        test_warm_refetch();
        test_redirect_in_flight();
        test_error_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
